// File: rtl/raster_pkg.sv
// Shared definitions for the raster fill engine.
//   - Command op codes as seen on cmd_op.
//   - FSM state encodings for the engine controller.
//   - A corner-normalise helper that turns two arbitrary corners into an
//     inclusive min/max box.
// Coordinates are handled at CW_MAX bits inside the helper. Callers
// zero-extend into it and slice the result back down to their own width.
package raster_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_PLOT  = 2'b01;
    localparam logic [1:0] OP_RECT  = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_PLOT  = 3'd2;
    localparam state_t ST_RECT  = 3'd3;
    localparam state_t ST_SCAN  = 3'd4;

    localparam int CW_MAX = 8;

    typedef struct packed {
        logic [CW_MAX-1:0] xmin;
        logic [CW_MAX-1:0] xmax;
        logic [CW_MAX-1:0] ymin;
        logic [CW_MAX-1:0] ymax;
    } rect_t;

    function automatic rect_t normalise(input logic [CW_MAX-1:0] x0,
                                        input logic [CW_MAX-1:0] y0,
                                        input logic [CW_MAX-1:0] x1,
                                        input logic [CW_MAX-1:0] y1);
        rect_t r;
        r.xmin = (x0 < x1) ? x0 : x1;
        r.xmax = (x0 < x1) ? x1 : x0;
        r.ymin = (y0 < y1) ? y0 : y1;
        r.ymax = (y0 < y1) ? y1 : y0;
        return r;
    endfunction

endpackage

// File: rtl/raster_span_walker.sv
// Raster-order walker over an inclusive box. X advances fastest.
// A start pulse loads the box and presents (xmin,ymin) in the next cycle.
// After that it presents one coordinate per cycle until the last coordinate
// (xmax,ymax), which is flagged with last. A start pulse always wins over
// a walk already in progress.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      load bounds and begin walking
//   xmin, xmax, ymin, ymax     inclusive box, already normalised
//   active                     x/y hold a coordinate to process this cycle
//   x, y                       current coordinate
//   last                       current coordinate is the final one
module raster_span_walker
    import raster_pkg::*;
#(
    parameter int COORD_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymin,
    input  logic [COORD_W-1:0] ymax,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W-1:0] xmin_q;
    logic [COORD_W-1:0] xmax_q;
    logic [COORD_W-1:0] ymax_q;

    assign last = active && (x == xmax_q) && (y == ymax_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            x      <= xmin;
            y      <= ymin;
            xmin_q <= xmin;
            xmax_q <= xmax;
            ymax_q <= ymax;
        end else if (active) begin
            if (x == xmax_q) begin
                x <= xmin_q;
                if (y == ymax_q) begin
                    active <= 1'b0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/raster_fill_engine.sv
// GRID_W x GRID_H 1-bit framebuffer with a valid/ready command port and a
// backpressured row-scanout port. The engine executes one command at a time.
//
// Optional feature macro: RASTER_XOR_EN
//   Defined:   PLOT/RECT with cmd_xor=1 invert the target pixel, ignoring
//              cmd_color.
//   Undefined: cmd_xor is ignored, and cmd_color is always written.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_op             00 CLEAR, 01 PLOT, 10 RECT, 11 SCAN
//   cmd_x0/y0/x1/y1    corners (PLOT uses x0/y0 only)
//   cmd_color          pixel value for PLOT/RECT
//   cmd_xor            XOR draw request
//   row_valid/ready    scanout handshake
//   row_data, row_idx  presented row (bit i = column i) and its number
//   done               one-cycle pulse when a command completes
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_CLEAR | zeroing row row_cnt, one row per cycle
// ST_PLOT  | writing the single pixel produced by the walker
// ST_RECT  | writing one walker pixel per cycle until the walker's last
// ST_SCAN  | presenting row row_cnt; advance on row handshake
module raster_fill_engine
    import raster_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int COORD_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic               cmd_color,
    input  logic               cmd_xor,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [GRID_W-1:0]  row_data,
    output logic [COORD_W-1:0] row_idx,
    output logic               done
);

    localparam int COL_AW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROW_AW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam logic [COORD_W:0] GRID_W_C = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0] GRID_H_C = (COORD_W+1)'(GRID_H);
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(GRID_H - 1);

    state_t             state;
    logic               color_q;
    logic [ROW_AW-1:0]  row_cnt;
    logic [GRID_W-1:0]  fb [GRID_H];

    logic               accept;
    logic               walk_start;
    rect_t              nrm;
    logic [4*CW_MAX-1:0] nrm_unused;
    logic [COORD_W-1:0] box_x1;
    logic [COORD_W-1:0] box_y1;

    logic               walk_active;
    logic               walk_last;
    logic [COORD_W-1:0] walk_x;
    logic [COORD_W-1:0] walk_y;

    logic               pix_in_grid;
    logic [COL_AW-1:0]  pix_col;
    logic [ROW_AW-1:0]  pix_row;
    logic               pix_val;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // PLOT goes through the walker as a degenerate 1x1 box. That gives it the
    // same write path and the same timing as a 1x1 RECT.
    assign box_x1     = (cmd_op == OP_PLOT) ? cmd_x0 : cmd_x1;
    assign box_y1     = (cmd_op == OP_PLOT) ? cmd_y0 : cmd_y1;
    assign nrm        = normalise(CW_MAX'(cmd_x0), CW_MAX'(cmd_y0),
                                  CW_MAX'(box_x1), CW_MAX'(box_y1));
    assign nrm_unused = nrm;
    assign walk_start = accept && ((cmd_op == OP_PLOT) || (cmd_op == OP_RECT));

    raster_span_walker #(
        .COORD_W (COORD_W)
    ) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (walk_start),
        .xmin   (nrm.xmin[COORD_W-1:0]),
        .xmax   (nrm.xmax[COORD_W-1:0]),
        .ymin   (nrm.ymin[COORD_W-1:0]),
        .ymax   (nrm.ymax[COORD_W-1:0]),
        .active (walk_active),
        .x      (walk_x),
        .y      (walk_y),
        .last   (walk_last)
    );

    // Out-of-grid coordinates still take their cycle. The write is simply
    // suppressed, so latency depends only on the box size.
    assign pix_in_grid = ({1'b0, walk_x} < GRID_W_C) && ({1'b0, walk_y} < GRID_H_C);
    assign pix_col     = walk_x[COL_AW-1:0];
    assign pix_row     = walk_y[ROW_AW-1:0];

`ifdef RASTER_XOR_EN
    logic xor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= 1'b0;
        end else if (accept) begin
            xor_q <= cmd_xor;
        end
    end

    assign pix_val = xor_q ? ~fb[pix_row][pix_col] : color_q;
`else
    logic xor_unused;
    assign xor_unused = cmd_xor;
    assign pix_val    = color_q;
`endif

    assign row_valid = (state == ST_SCAN);
    assign row_data  = row_valid ? fb[row_cnt] : '0;
    assign row_idx   = row_valid ? COORD_W'(row_cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            color_q <= 1'b0;
            row_cnt <= '0;
            done    <= 1'b0;
            for (int r = 0; r < GRID_H; r++) begin
                fb[r] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        color_q <= cmd_color;
                        row_cnt <= '0;
                        case (cmd_op)
                            OP_CLEAR: state <= ST_CLEAR;
                            OP_PLOT:  state <= ST_PLOT;
                            OP_RECT:  state <= ST_RECT;
                            default:  state <= ST_SCAN;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    fb[row_cnt] <= '0;
                    if (row_cnt == LAST_ROW) begin
                        row_cnt <= '0;
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                ST_PLOT, ST_RECT: begin
                    if (walk_active && pix_in_grid) begin
                        fb[pix_row][pix_col] <= pix_val;
                    end
                    if (walk_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (row_ready) begin
                        if (row_cnt == LAST_ROW) begin
                            row_cnt <= '0;
                            state   <= ST_IDLE;
                            done    <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_fill_engine.sv
// Testbench for raster_fill_engine at its default 8x8 geometry.
// Honours RASTER_XOR_EN in the same way the design does.
module tb_raster_fill_engine;
    import raster_pkg::*;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_x0;
    logic [CW-1:0] cmd_y0;
    logic [CW-1:0] cmd_x1;
    logic [CW-1:0] cmd_y1;
    logic          cmd_color;
    logic          cmd_xor;
    logic          row_valid;
    logic          row_ready;
    logic [GW-1:0] row_data;
    logic [CW-1:0] row_idx;
    logic          done;

    raster_fill_engine #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .COORD_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .cmd_xor   (cmd_xor),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        int         x0;
        int         y0;
        int         x1;
        int         y1;
        logic       color;
        logic       xr;
        int         exp_lat;
    } vec_t;

    typedef struct {
        int            idx;
        logic [GW-1:0] data;
    } row_t;

    vec_t          vecs[$];
    row_t          exp_q[$];
    logic [GW-1:0] mfb [GH];
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic model_cmd(input vec_t v);
        int xa, xb, ya, yb;
        case (v.op)
            OP_CLEAR: for (int r = 0; r < GH; r++) mfb[r] = '0;
            OP_SCAN:  for (int r = 0; r < GH; r++) exp_q.push_back('{r, mfb[r]});
            default: begin
                xb = (v.op == OP_PLOT) ? v.x0 : v.x1;
                yb = (v.op == OP_PLOT) ? v.y0 : v.y1;
                xa = (v.x0 < xb) ? v.x0 : xb;
                xb = (v.x0 < xb) ? xb : v.x0;
                ya = (v.y0 < yb) ? v.y0 : yb;
                yb = (v.y0 < yb) ? yb : v.y0;
                for (int y = ya; y <= yb; y++) begin
                    for (int x = xa; x <= xb; x++) begin
                        if (x < GW && y < GH) begin
`ifdef RASTER_XOR_EN
                            if (v.xr) mfb[y][x] = ~mfb[y][x];
                            else      mfb[y][x] = v.color;
`else
                            mfb[y][x] = v.color;
`endif
                        end
                    end
                end
            end
        endcase
    endtask

    // Scoreboard side: pop expected rows on each row handshake, and confirm
    // that a stalled row stays put until it is taken.
    logic          stall_prev = 1'b0;
    logic [GW-1:0] held_data;
    logic [CW-1:0] held_idx;
    row_t          got;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", row_valid, 1);
                check("stall_data", row_data, held_data);
                check("stall_idx", row_idx, held_idx);
            end
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_row: got idx %0d data 0x%0h, want no row", row_idx, row_data);
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("row_idx[%0d]", got.idx), row_idx, got.idx);
                    check($sformatf("row_data[%0d]", got.idx), row_data, got.data);
                end
            end
            stall_prev = row_valid && !row_ready;
            held_data  = row_data;
            held_idx   = row_idx;
        end
    end

    task automatic drive_cmd(input vec_t v);
        cmd_op    = v.op;
        cmd_x0    = CW'(v.x0);
        cmd_y0    = CW'(v.y0);
        cmd_x1    = CW'(v.x1);
        cmd_y1    = CW'(v.y1);
        cmd_color = v.color;
        cmd_xor   = v.xr;
        cmd_valid = 1'b1;
    endtask

    // Issue one command and measure its latency in cycles. The accept cycle
    // is cycle 0. Returns -1 if done never arrives within the bound.
    task automatic run_cmd(input vec_t v, input int ready_mode, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_ready_before_issue", cmd_ready, 1);
        model_cmd(v);
        drive_cmd(v);
        row_ready = (ready_mode == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            row_ready = (ready_mode == 0) || (lat % 3 == 0);
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        row_ready = 1'b1;
    endtask

    int lat;
    int done_cnt;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_color = 1'b0;
        cmd_xor   = 1'b0;
        row_ready = 1'b1;
        for (int r = 0; r < GH; r++) mfb[r] = '0;

        //           op        x0 y0 x1 y1 col xor lat
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_PLOT,  3, 5, 0, 0, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_PLOT,  9, 2, 0, 0, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_PLOT,  7, 7, 0, 0, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_RECT,  6, 1, 2, 3, 1'b1, 1'b0, 16});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_RECT,  9, 7, 6, 6, 1'b1, 1'b0, 9});
        vecs.push_back('{OP_RECT,  2, 2, 2, 2, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_CLEAR, 0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_RECT,  0, 0, 3, 0, 1'b1, 1'b1, 5});
        vecs.push_back('{OP_PLOT,  1, 0, 0, 0, 1'b1, 1'b1, 2});
        vecs.push_back('{OP_SCAN,  0, 0, 0, 0, 1'b0, 1'b0, 9});

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_cmd(vecs[i], 0, lat);
            check($sformatf("latency[%0d]", i), lat, vecs[i].exp_lat);
            check($sformatf("ready_at_done[%0d]", i), cmd_ready, 1);
            check($sformatf("row_valid_at_done[%0d]", i), row_valid, 0);
            @(posedge clk); #1;
            check($sformatf("done_width[%0d]", i), done, 0);
        end
        check("rows_outstanding_a", exp_q.size(), 0);

        // Backpressured scan over a non-trivial picture.
        run_cmd('{OP_RECT, 1, 4, 5, 6, 1'b1, 1'b0, 0}, 0, lat);
        check("stall_setup_lat", lat, 16);
        run_cmd('{OP_SCAN, 0, 0, 0, 0, 1'b0, 1'b0, 0}, 1, lat);
        check("stall_scan_done", lat > 9, 1);
        check("rows_outstanding_b", exp_q.size(), 0);

        // Reset while a full-grid RECT is in flight.
        drive_cmd('{OP_RECT, 0, 0, 7, 7, 1'b1, 1'b0, 0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        done_cnt  = 0;
        for (int c = 1; c < 20; c++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_done", done, 0);
        check("abort_row_valid", row_valid, 0);
        for (int r = 0; r < GH; r++) mfb[r] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_cmd('{OP_SCAN, 0, 0, 0, 0, 1'b0, 1'b0, 0}, 0, lat);
        check("abort_scan_lat", lat, 9);
        check("rows_outstanding_c", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
